// File: rtl/path_pqueue_relax.sv
// Sorted-array priority queue with PUSH/POP and a two-cycle RELAX (decrease-key-or-insert).
// Slot 0 always holds the minimum key; every output is a register.
module path_pqueue_relax #(
    parameter int DEPTH = 16,
    parameter int KEY_W = 16,
    parameter int ID_W  = 16,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             system1000,
    input  logic             system1000_rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [KEY_W-1:0] cmd_key,
    input  logic [ID_W-1:0]  cmd_id,
    output logic             head_valid,
    output logic [KEY_W-1:0] head_key,
    output logic [ID_W-1:0]  head_id,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             err_ovf,
    output logic             err_udf
);

    typedef enum logic [0:0] {IDLE = 1'b0, RLX_INS = 1'b1} state_t;

    localparam logic [1:0]       OP_PUSH  = 2'd1;
    localparam logic [1:0]       OP_POP   = 2'd2;
    localparam logic [1:0]       OP_RELAX = 2'd3;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    state_t           state_q, state_d;
    logic             vld_q [DEPTH];
    logic             vld_d [DEPTH];
    logic [KEY_W-1:0] key_q [DEPTH];
    logic [KEY_W-1:0] key_d [DEPTH];
    logic [ID_W-1:0]  id_q  [DEPTH];
    logic [ID_W-1:0]  id_d  [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d, empty_q, empty_d, ready_q, ready_d;
    logic             err_ovf_q, err_ovf_d, err_udf_q, err_udf_d;
    logic [KEY_W-1:0] pend_key_q, pend_key_d;
    logic [ID_W-1:0]  pend_id_q, pend_id_d;
    logic             pend_en_q, pend_en_d;

    logic [KEY_W-1:0] ins_key_s;
    logic [ID_W-1:0]  ins_id_s;
    logic             do_ins_s, do_rem_s, found_s;
    int               ins_pos_s, rem_idx_s, found_idx_s;

    // Next-state logic: command decode, id search, sorted insert and remove-with-shift.
    always_comb begin
        state_d    = state_q;
        vld_d      = vld_q;
        key_d      = key_q;
        id_d       = id_q;
        count_d    = count_q;
        err_ovf_d  = err_ovf_q;
        err_udf_d  = err_udf_q;
        pend_key_d = pend_key_q;
        pend_id_d  = pend_id_q;
        pend_en_d  = pend_en_q;
        do_ins_s   = 1'b0;
        do_rem_s   = 1'b0;
        rem_idx_s  = 0;
        ins_key_s  = (state_q == RLX_INS) ? pend_key_q : cmd_key;
        ins_id_s   = (state_q == RLX_INS) ? pend_id_q : cmd_id;

        // Insert goes before the first strictly larger key, so equal keys keep arrival order.
        ins_pos_s = int'(count_q);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            ins_pos_s = (vld_q[i] && (key_q[i] > ins_key_s)) ? i : ins_pos_s;
        end
        found_s     = 1'b0;
        found_idx_s = 0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            found_idx_s = (vld_q[i] && (id_q[i] == cmd_id)) ? i : found_idx_s;
            found_s     = found_s | (vld_q[i] && (id_q[i] == cmd_id));
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_PUSH: do_ins_s = 1'b1;
                        OP_POP: begin
                            if (count_q == '0) begin
                                err_udf_d = 1'b1;
                            end else begin
                                do_rem_s  = 1'b1;
                                rem_idx_s = 0;
                            end
                        end
                        OP_RELAX: begin
                            state_d    = RLX_INS;
                            pend_key_d = cmd_key;
                            pend_id_d  = cmd_id;
                            if (found_s && (key_q[found_idx_s] <= cmd_key)) begin
                                pend_en_d = 1'b0;
                            end else begin
                                pend_en_d = 1'b1;
                                do_rem_s  = found_s;
                                rem_idx_s = found_idx_s;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            RLX_INS: begin
                state_d  = IDLE;
                do_ins_s = pend_en_q;
            end
            default: state_d = IDLE;
        endcase

        if (do_ins_s) begin
            if (count_q == CNT_FULL) begin
                err_ovf_d = 1'b1;
            end else begin
                for (int i = 1; i < DEPTH; i++) begin
                    if (i > ins_pos_s) begin
                        vld_d[i] = vld_q[i-1];
                        key_d[i] = key_q[i-1];
                        id_d[i]  = id_q[i-1];
                    end else begin
                        vld_d[i] = vld_q[i];
                    end
                end
                vld_d[ins_pos_s] = 1'b1;
                key_d[ins_pos_s] = ins_key_s;
                id_d[ins_pos_s]  = ins_id_s;
                count_d          = count_q + CNT_W'(1);
            end
        end else if (do_rem_s) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (i >= rem_idx_s) begin
                    vld_d[i] = vld_q[i+1];
                    key_d[i] = key_q[i+1];
                    id_d[i]  = id_q[i+1];
                end else begin
                    vld_d[i] = vld_q[i];
                end
            end
            vld_d[DEPTH-1] = 1'b0;
            key_d[DEPTH-1] = '1;
            id_d[DEPTH-1]  = '0;
            count_d        = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end

        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == '0);
        ready_d = (state_d == IDLE);
    end

    // State, storage and registered status flags.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_q    <= IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                vld_q[i] <= 1'b0;
                key_q[i] <= '1;
                id_q[i]  <= '0;
            end
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            ready_q    <= 1'b1;
            err_ovf_q  <= 1'b0;
            err_udf_q  <= 1'b0;
            pend_key_q <= '0;
            pend_id_q  <= '0;
            pend_en_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            vld_q      <= vld_d;
            key_q      <= key_d;
            id_q       <= id_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            ready_q    <= ready_d;
            err_ovf_q  <= err_ovf_d;
            err_udf_q  <= err_udf_d;
            pend_key_q <= pend_key_d;
            pend_id_q  <= pend_id_d;
            pend_en_q  <= pend_en_d;
        end
    end

    assign cmd_ready  = ready_q;
    assign head_valid = vld_q[0];
    assign head_key   = key_q[0];
    assign head_id    = id_q[0];
    assign count      = count_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign err_ovf    = err_ovf_q;
    assign err_udf    = err_udf_q;

endmodule

// File: tb/tb_path_pqueue_relax.sv
// Scoreboard bench for path_pqueue_relax (DEPTH=4): driver queues expected post-edge state,
// a negedge monitor pops and compares it against the DUT outputs.
module tb_path_pqueue_relax;

    localparam int DEPTH = 4;
    localparam int KEY_W = 16;
    localparam int ID_W  = 16;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] NOP = 2'd0, PUSH = 2'd1, POP = 2'd2, RELAX = 2'd3;
    localparam logic [15:0] ONES = 16'hFFFF;

    typedef struct packed {
        logic             hv;
        logic [KEY_W-1:0] hk;
        logic [ID_W-1:0]  hid;
        logic [CNT_W-1:0] cnt;
        logic             full;
        logic             empty;
        logic             ovf;
        logic             udf;
        logic             rdy;
    } snap_t;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [KEY_W-1:0] cmd_key;
    logic [ID_W-1:0]  cmd_id;
    logic             head_valid;
    logic [KEY_W-1:0] head_key;
    logic [ID_W-1:0]  head_id;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             err_ovf;
    logic             err_udf;

    snap_t exp_q [$];
    string name_q [$];
    int    n_tests = 0;
    int    n_fail  = 0;

    path_pqueue_relax #(.DEPTH(DEPTH), .KEY_W(KEY_W), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .system1000      (clk),
        .system1000_rstn (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_key         (cmd_key),
        .cmd_id          (cmd_id),
        .head_valid      (head_valid),
        .head_key        (head_key),
        .head_id         (head_id),
        .count           (count),
        .full            (full),
        .empty           (empty),
        .err_ovf         (err_ovf),
        .err_udf         (err_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare each queued expectation on the falling edge after it was issued.
    always @(negedge clk) begin
        snap_t act, exp;
        string nm;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {head_valid, head_key, head_id, count, full, empty, err_ovf, err_udf, cmd_ready};
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL %s: got hv=%0b key=%0d id=%0d cnt=%0d full=%0b empty=%0b ovf=%0b udf=%0b rdy=%0b, want hv=%0b key=%0d id=%0d cnt=%0d full=%0b empty=%0b ovf=%0b udf=%0b rdy=%0b",
                         nm, act.hv, act.hk, act.hid, act.cnt, act.full, act.empty, act.ovf, act.udf, act.rdy,
                         exp.hv, exp.hk, exp.hid, exp.cnt, exp.full, exp.empty, exp.ovf, exp.udf, exp.rdy);
            end
        end
    end

    task automatic issue(input logic v, input logic [1:0] op, input logic [15:0] k, input logic [15:0] id);
        cmd_valid = v;
        cmd_op    = op;
        cmd_key   = k;
        cmd_id    = id;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = NOP;
    endtask

    task automatic expect_st(input string nm, input logic hv, input logic [15:0] hk, input logic [15:0] hid,
                             input int cnt, input logic f, input logic e, input logic ovf,
                             input logic udf, input logic rdy);
        snap_t s;
        s = {hv, hk, hid, CNT_W'(cnt), f, e, ovf, udf, rdy};
        exp_q.push_back(s);
        name_q.push_back(nm);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = NOP; cmd_key = '0; cmd_id = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        expect_st("reset", 0, ONES, 0, 0, 0, 1, 0, 0, 1);
        issue(0, NOP, 0, 0);

        // Sorted insert and POP order
        issue(1, PUSH, 30, 3); expect_st("push30", 1, 30, 3, 1, 0, 0, 0, 0, 1);
        issue(1, PUSH, 10, 1); expect_st("push10", 1, 10, 1, 2, 0, 0, 0, 0, 1);
        issue(1, PUSH, 20, 2); expect_st("push20", 1, 10, 1, 3, 0, 0, 0, 0, 1);
        issue(1, POP, 0, 0);   expect_st("pop1", 1, 20, 2, 2, 0, 0, 0, 0, 1);
        issue(1, POP, 0, 0);   expect_st("pop2", 1, 30, 3, 1, 0, 0, 0, 0, 1);
        issue(1, POP, 0, 0);   expect_st("pop3", 0, ONES, 0, 0, 0, 1, 0, 0, 1);
        issue(1, POP, 0, 0);   expect_st("pop_udf", 0, ONES, 0, 0, 0, 1, 0, 1, 1);

        // Fill to DEPTH, overflow drop, drain in order
        for (int i = 1; i <= 4; i++) begin
            issue(1, PUSH, 16'(i), 16'(i));
            expect_st("fill", 1, 1, 1, i, (i == 4), 0, 0, 1, 1);
        end
        issue(1, PUSH, 5, 5); expect_st("push_ovf", 1, 1, 1, 4, 1, 0, 1, 1, 1);
        for (int i = 2; i <= 5; i++) begin
            issue(1, POP, 0, 0);
            if (i <= 4) expect_st("drain", 1, 16'(i), 16'(i), 5 - i, 0, 0, 1, 1, 1);
            else        expect_st("drain_last", 0, ONES, 0, 0, 0, 1, 1, 1, 1);
        end

        // RELAX decrease-key, then no-op RELAX with a blocked PUSH during RLX_INS
        issue(1, PUSH, 50, 7);  expect_st("push50", 1, 50, 7, 1, 0, 0, 1, 1, 1);
        issue(1, RELAX, 40, 7); expect_st("rlx_rem", 0, ONES, 0, 0, 0, 1, 1, 1, 0);
        issue(0, NOP, 0, 0);    expect_st("rlx_ins", 1, 40, 7, 1, 0, 0, 1, 1, 1);
        issue(1, RELAX, 45, 7); expect_st("rlx_noop1", 1, 40, 7, 1, 0, 0, 1, 1, 0);
        issue(1, PUSH, 1, 99);  expect_st("rlx_noop2", 1, 40, 7, 1, 0, 0, 1, 1, 1);
        issue(1, POP, 0, 0);    expect_st("pop_rlx", 0, ONES, 0, 0, 0, 1, 1, 1, 1);

        // RELAX on empty queue inserts
        issue(1, RELAX, 9, 12); expect_st("rlx_empty1", 0, ONES, 0, 0, 0, 1, 1, 1, 0);
        issue(0, NOP, 0, 0);    expect_st("rlx_empty2", 1, 9, 12, 1, 0, 0, 1, 1, 1);
        issue(1, POP, 0, 0);    expect_st("pop_e", 0, ONES, 0, 0, 0, 1, 1, 1, 1);

        // Decrease-key of a middle entry re-sorts it
        issue(1, PUSH, 10, 1);  expect_st("m_push1", 1, 10, 1, 1, 0, 0, 1, 1, 1);
        issue(1, PUSH, 20, 2);  expect_st("m_push2", 1, 10, 1, 2, 0, 0, 1, 1, 1);
        issue(1, PUSH, 30, 3);  expect_st("m_push3", 1, 10, 1, 3, 0, 0, 1, 1, 1);
        issue(1, RELAX, 15, 3); expect_st("m_rlx1", 1, 10, 1, 2, 0, 0, 1, 1, 0);
        issue(0, NOP, 0, 0);    expect_st("m_rlx2", 1, 10, 1, 3, 0, 0, 1, 1, 1);
        issue(1, POP, 0, 0);    expect_st("m_pop1", 1, 15, 3, 2, 0, 0, 1, 1, 1);
        issue(1, POP, 0, 0);    expect_st("m_pop2", 1, 20, 2, 1, 0, 0, 1, 1, 1);
        issue(1, POP, 0, 0);    expect_st("m_pop3", 0, ONES, 0, 0, 0, 1, 1, 1, 1);

        // Equal keys keep insertion order; reset during RLX_INS
        issue(1, PUSH, 8, 1);   expect_st("eq_push1", 1, 8, 1, 1, 0, 0, 1, 1, 1);
        issue(1, PUSH, 8, 2);   expect_st("eq_push2", 1, 8, 1, 2, 0, 0, 1, 1, 1);
        issue(1, POP, 0, 0);    expect_st("eq_pop", 1, 8, 2, 1, 0, 0, 1, 1, 1);
        issue(1, RELAX, 3, 5);
        rst_n = 1'b0;
        expect_st("rst_in_rlx", 0, ONES, 0, 0, 0, 1, 0, 0, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        issue(0, NOP, 0, 0);    expect_st("after_rst", 0, ONES, 0, 0, 0, 1, 0, 0, 1);

        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_queue: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/path_pqueue_relax.md
# path_pqueue_relax

Parametrised sorted-array priority queue for the path-search datapath, the successor to the fixed 1000-entry, 16-bit-key queue state machine. Holds up to DEPTH entries of {key, id}, ordered by ascending key, and always presents the minimum entry on registered head outputs. It adds a valid/ready command handshake, explicit full/empty/count status, sticky error flags, and a two-cycle RELAX (decrease-key-or-insert) operation, so the Dijkstra front end no longer needs separate search logic.

## Interface
- DEPTH, 16: number of entry slots (≥2).
- KEY_W, 16: key (distance) width, unsigned.
- ID_W, 16: node id width.
- CNT_W, $clog2(DEPTH+1): width of count.
- system1000  in  1  clock; all state updates on the rising edge.
- system1000_rstn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when cmd_valid && cmd_ready.
- cmd_op  in  2  0=NOP, 1=PUSH, 2=POP, 3=RELAX.
- cmd_key  in  KEY_W  key for PUSH/RELAX.
- cmd_id  in  ID_W  id for PUSH/RELAX.
- head_valid  out  1  queue non-empty.
- head_key  out  KEY_W  key of slot 0.
- head_id  out  ID_W  id of slot 0.
- count  out  CNT_W  number of occupied slots.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- err_ovf  out  1  sticky: an insert was dropped because the queue was full.
- err_udf  out  1  sticky: a POP was issued while empty.

## Operation
- Storage: slots 0..DEPTH-1, each {valid, key, id}. Occupied slots are contiguous from slot 0 and sorted by ascending key. Equal keys are kept in insertion order (a new entry goes after all existing entries with the same key).
- Reset: every slot is {0, all-ones, 0}; count=0; both err flags 0; FSM in IDLE; cmd_ready=1. Head outputs therefore reset to head_valid=0, head_key=all-ones, head_id=0.
- FSM states and transitions:
  - IDLE: cmd_ready=1. An accepted RELAX moves the FSM to RLX_INS; any other command stays in IDLE.
  - RLX_INS: cmd_ready=0. Performs the insert phase of the RELAX, then returns to IDLE unconditionally.
- PUSH (IDLE):
  - Not full: the entry is inserted at its sorted position, slots below it shift down by one, and count increments.
  - Full: the entry is dropped, the array is unchanged, and err_ovf is set.
- POP (IDLE):
  - Not empty: slots shift up by one, the last slot is cleared to its reset value, and count decrements.
  - Empty: no change; err_udf is set.
- RELAX, cycle 1 (IDLE): search for the lowest-index valid slot whose id equals cmd_id.
  - Found with stored key ≤ cmd_key: no change, and the insert phase is cancelled.
  - Found with stored key > cmd_key: that slot is removed (slots below it shift up, count decrements) and the insert is latched.
  - Not found: the insert is latched.
- RELAX, cycle 2 (RLX_INS): the latched {key, id} is inserted exactly as a PUSH, including drop and err_ovf when full. A removed entry always frees a slot, so a decrease-key never overflows.
- NOP, or cmd_valid=0: no state change.
- err_ovf and err_udf clear only on reset.
- Arithmetic: key comparisons are unsigned, KEY_W bits wide. count never wraps: saturation is prevented by the full/empty rules above.

## Timing
- All outputs come directly from registers; there is no combinational path from cmd_* to any output, including cmd_ready, which depends only on FSM state.
- PUSH/POP accepted at edge N: the head, count, full, empty and err outputs reflect the result from edge N onward. One command per cycle, back to back.
- RELAX accepted at edge N: the removal is visible after edge N. The insert and the final head/count are visible after edge N+1. cmd_ready is low for the one cycle between N and N+1.
- An asserted reset in RLX_INS abandons the pending insert and returns the block to its reset state immediately, without waiting for a clock edge.
- Throughput: 1 command/cycle for PUSH/POP/NOP; 1 RELAX per 2 cycles.

## Test plan
- Reset, then PUSH keys 30, 10, 20 (ids 3, 1, 2) on consecutive cycles. Expected: head_key/head_id = 30/3, then 10/1, then 10/1; count=3.
- POP ×3, then a 4th POP on the empty queue. Expected: head sequence 20/2, 30/3, then head_valid=0 with head_key=all-ones; the 4th POP sets err_udf=1, count stays 0.
- With DEPTH=4, PUSH 5 entries (keys 1..5). Expected: full=1 after the 4th PUSH; the 5th is dropped and err_ovf=1; POP order is 1,2,3,4.
- PUSH {key 50, id 7}, then RELAX {key 40, id 7}, then RELAX {key 45, id 7}. Expected: cmd_ready=0 for one cycle after each RELAX; final state count=1, head = 40/7 (the second RELAX is a no-op).
- RELAX {key 9, id 12} on an empty queue. Expected: count=1 and head = 9/12 two edges after acceptance.
- PUSH key 8 with id 1 then id 2 (equal keys), then assert reset while in RLX_INS. Expected: POP returns id 1 before id 2; after reset, all outputs return to their reset values and cmd_ready=1.
